filter_8b_8tap_stream: RTL and testbench

Streaming front end for the 8-bit, 8-tap FIR datapath (coefficients 1..8). It accepts one 8-bit sample per valid/ready handshake and maintains the 8-sample tap window that the parallel filter consumes as a packed 64-bit word. It computes the same weighted sum with a sequential 8-cycle multiply-accumulate and presents the result and the window on a valid/ready output. It sits between a serial sample source and any consumer of filtered results or packed tap windows.

---
 rtl/filter_8b_8tap_pkg.sv | 38 +++
 rtl/filter_8b_8tap_stream_if.sv | 27 ++
 rtl/filter_8b_8tap_window.sv | 41 ++++
 rtl/filter_8b_8tap_stream.sv | 94 +++++++++
 tb/tb_filter_8b_8tap_stream.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/filter_8b_8tap_pkg.sv
// Shared constants, state type and shift/add multiply helper for the
// 8-bit, 8-tap streaming FIR front end.
package filter_8b_8tap_pkg;

  localparam int TAPS     = 8;
  localparam int SAMPLE_W = 8;
  localparam int ACC_W    = 14;
  localparam int IDX_W    = 3;
  localparam int CNT_W    = 4;
  localparam int COEFF_W  = 4;

  localparam logic [COEFF_W-1:0] COEFF [TAPS] = '{
    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Coefficients are at most 4 bits, so the product is a sum of up to four
  // shifted copies of the sample.
  function automatic logic [ACC_W-1:0] shift_add_mul(
    input logic [SAMPLE_W-1:0] s,
    input logic [COEFF_W-1:0]  c
  );
    logic [ACC_W-1:0] p;
    logic [ACC_W-1:0] ext;
    p   = '0;
    ext = ACC_W'(s);
    for (int b = 0; b < COEFF_W; b++) begin
      if (c[b]) p = p + (ext << b);
    end
    return p;
  endfunction

endpackage

// File: rtl/filter_8b_8tap_stream_if.sv
// Sample-in / result-out handshake bundle. slave is the filter side,
// master is the source/consumer side.
interface filter_8b_8tap_stream_if #(
  parameter int OUT_W = 12
);
  import filter_8b_8tap_pkg::*;

  logic                       s_valid;
  logic                       s_ready;
  logic [SAMPLE_W-1:0]        s_data;
  logic                       m_valid;
  logic                       m_ready;
  logic [OUT_W-1:0]           m_data;
  logic [TAPS*SAMPLE_W-1:0]   m_window;
  logic                       m_primed;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_window, m_primed
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_window, m_primed
  );

endinterface

// File: rtl/filter_8b_8tap_window.sv
// 8-deep sample shift register (tap[0] newest) plus a fill counter that
// saturates at TAPS to flag a primed window.
module filter_8b_8tap_window
  import filter_8b_8tap_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en_i,
  input  logic [SAMPLE_W-1:0]      sample_i,
  output logic [TAPS*SAMPLE_W-1:0] window_o,
  output logic                     primed_o
);

  logic [TAPS-1:0][SAMPLE_W-1:0] tap_q;
  logic [CNT_W-1:0]              cnt_q;

  for (genvar t = 0; t < TAPS; t++) begin : g_tap
    if (t == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst)             tap_q[t] <= '0;
        else if (shift_en_i) tap_q[t] <= sample_i;
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (rst)             tap_q[t] <= '0;
        else if (shift_en_i) tap_q[t] <= tap_q[t-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (shift_en_i && (cnt_q != CNT_W'(TAPS)))
      cnt_q <= cnt_q + 1'b1;
  end

  assign window_o = tap_q;
  assign primed_o = (cnt_q == CNT_W'(TAPS));

endmodule

// File: rtl/filter_8b_8tap_stream.sv
// Streaming 8-tap FIR: one sample per handshake, sequential 8-cycle
// shift/add MAC, result held on a valid/ready output.
// Define FILTER_8B_8TAP_STREAM_SAT_EN to saturate m_data instead of wrapping.
module filter_8b_8tap_stream
  import filter_8b_8tap_pkg::*;
#(
  parameter int OUT_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  filter_8b_8tap_stream_if.slave  io
);

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [ACC_W-1:0]              acc_q, acc_d;
  logic [OUT_W-1:0]              data_q, data_d;
  logic [ACC_W-1:0]              sum;
  logic [OUT_W-1:0]              res;
  logic                          shift_en;
  logic                          ready;
  logic [TAPS-1:0][SAMPLE_W-1:0] win;

  filter_8b_8tap_window u_window (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en),
    .sample_i   (io.s_data),
    .window_o   (win),
    .primed_o   (io.m_primed)
  );

  assign sum = acc_q + shift_add_mul(win[idx_q], COEFF[idx_q]);

`ifdef FILTER_8B_8TAP_STREAM_SAT_EN
  localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUT_W) - 1);
  assign res = (sum > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : sum[OUT_W-1:0];
`else
  assign res = sum[OUT_W-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    data_d   = data_q;
    shift_en = 1'b0;
    ready    = 1'b0;
    case (state_q)
      IDLE: begin
        // rst gates ready so nothing is offered while reset is held
        ready = ~rst;
        if (io.s_valid && ready) begin
          shift_en = 1'b1;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(TAPS - 1)) begin
          data_d  = res;
          state_d = OUT;
        end
      end
      OUT: begin
        if (io.m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
    end
  end

  assign io.s_ready  = ready;
  assign io.m_valid  = (state_q == OUT);
  assign io.m_data   = data_q;
  assign io.m_window = win;

endmodule

// File: tb/tb_filter_8b_8tap_stream.sv
// Directed + randomized bench for filter_8b_8tap_stream against a
// sample-history reference model.
module tb_filter_8b_8tap_stream;
  import filter_8b_8tap_pkg::*;

  localparam int OUT_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  filter_8b_8tap_stream_if #(.OUT_W(OUT_W)) io ();

  filter_8b_8tap_stream #(.OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] hist[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window = last eight accepted samples, newest in the low byte, zero-filled.
  function automatic logic [63:0] ref_win();
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++)
      if (i < hist.size()) w[8*i +: 8] = hist[hist.size()-1-i];
    return w;
  endfunction

  function automatic logic [63:0] ref_res();
    int s = 0;
    for (int i = 0; i < 8; i++)
      if (i < hist.size()) s += (i + 1) * int'(hist[hist.size()-1-i]);
`ifdef FILTER_8B_8TAP_STREAM_SAT_EN
    if (s > (1 << OUT_W) - 1) s = (1 << OUT_W) - 1;
`else
    s = s % (1 << OUT_W);
`endif
    return 64'(s);
  endfunction

  function automatic logic ref_primed();
    return hist.size() >= 8;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hist.delete();
  endtask

  // One full transaction; hold = cycles m_ready stays low once in OUT.
  task automatic send(input logic [7:0] d, input int hold);
    int n = 0;
    while (!io.s_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_s_ready", io.s_ready, 1);
    io.s_valid = 1'b1;
    io.s_data  = d;
    io.m_ready = (hold == 0);
    @(posedge clk); #1;
    hist.push_back(d);
    chk("hs_primed", io.m_primed, ref_primed());
    chk("hs_window", io.m_window, ref_win());
    chk("hs_busy",   io.s_ready, 0);
    for (int c = 1; c <= 7; c++) begin
      io.s_valid = 1'($urandom);
      io.s_data  = 8'($urandom);
      @(posedge clk); #1;
      chk("calc_no_valid", io.m_valid, 0);
    end
    io.s_valid = 1'b1;
    io.s_data  = 8'($urandom);
    @(posedge clk); #1;
    io.s_valid = 1'b0;
    chk("out_valid",  io.m_valid, 1);
    chk("out_data",   io.m_data, ref_res());
    chk("out_window", io.m_window, ref_win());
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk("bp_valid",  io.m_valid, 1);
      chk("bp_data",   io.m_data, ref_res());
      chk("bp_window", io.m_window, ref_win());
      chk("bp_ready",  io.s_ready, 0);
    end
    io.m_ready = 1'b1;
    @(posedge clk); #1;
    chk("ret_valid", io.m_valid, 0);
    chk("ret_ready", io.s_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int nhs;
    logic [63:0] q[$];

    io.s_valid = 1'b0;
    io.s_data  = '0;
    io.m_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready",  io.s_ready, 0);
    chk("rst_m_valid",  io.m_valid, 0);
    chk("rst_m_data",   io.m_data, 0);
    chk("rst_m_window", io.m_window, 0);
    chk("rst_m_primed", io.m_primed, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", io.s_ready, 1);

    // single sample
    send(8'd10, 0);
    chk("single_data",   io.m_data, 10);
    chk("single_window", io.m_window, 64'h0A);
    chk("single_primed", io.m_primed, 0);

    // ramp
    do_reset();
    for (int v = 1; v <= 8; v++) send(8'(v), 0);
    chk("ramp_data",   io.m_data, 120);
    chk("ramp_window", io.m_window, 64'h0102030405060708);
    chk("ramp_primed", io.m_primed, 1);

    // overflow
    do_reset();
    for (int v = 0; v < 8; v++) send(8'd255, 0);
`ifdef FILTER_8B_8TAP_STREAM_SAT_EN
    chk("ovf_data", io.m_data, 4095);
`else
    chk("ovf_data", io.m_data, 988);
`endif

    // backpressure, then random samples with random stall lengths
    send(8'($urandom), 20);
    for (int r = 0; r < 6; r++) send(8'($urandom), $urandom_range(0, 3));

    // reset four cycles after a handshake
    io.s_valid = 1'b1;
    io.s_data  = 8'd77;
    @(posedge clk); #1;
    io.s_valid = 1'b0;
    chk("mid_busy", io.s_ready, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", io.s_ready, 0);
    @(posedge clk); #1;
    chk("mid_window", io.m_window, 0);
    chk("mid_primed", io.m_primed, 0);
    chk("mid_valid",  io.m_valid, 0);
    chk("mid_data",   io.m_data, 0);
    rst = 1'b0;
    hist.delete();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk("mid_no_valid", io.m_valid, 0);
    end
    send(8'd5, 0);
    chk("mid_after_data", io.m_data, 5);

    // streaming with s_valid and m_ready held high
    last = -1;
    nhs  = 0;
    for (int cyc = 0; cyc < 115; cyc++) begin
      @(negedge clk);
      io.s_valid = (cyc < 100);
      io.s_data  = 8'($urandom);
      if (io.s_valid && io.s_ready) begin
        if (last >= 0) chk("stream_interval", 64'(cyc - last), 10);
        last = cyc;
        nhs++;
        hist.push_back(io.s_data);
        q.push_back(ref_res());
      end
      if (io.m_valid) begin
        if (q.size() == 0) chk("stream_extra", 1, 0);
        else begin
          chk("stream_window", io.m_window, ref_win());
          chk("stream_data", io.m_data, q.pop_front());
        end
      end
    end
    chk("stream_drained", 64'(q.size()), 0);
    chk("stream_count", 64'(nhs), 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
